// File: rtl/phy_par2serial_if.sv
// Byte-lane to serializer bus.
//   data_in    : parallel word from the multiplexer stage
//   valid_in   : data_in qualifier
//   serial_out : serial bit stream, MSB first
//   load       : high in the cycle whose closing edge samples data_in/valid_in
//   active     : high once alignment is done and data words are accepted
// master = upstream driver (and observer of the line), slave = serializer.
interface phy_par2serial_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       serial_out;
    logic       load;
    logic       active;

    modport master (
        output data_in,
        output valid_in,
        input  serial_out,
        input  load,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output serial_out,
        output load,
        output active
    );
endinterface

// File: rtl/phy_par2serial.sv
// Transmit parallel-to-serial converter.
// After reset it sends N_SYNC COM symbols so the receiver can align, then
// serializes one word every 8 clocks, MSB first: the sampled data word when
// valid_in is high at a load edge, otherwise IDLE. No backpressure.
// Ports:
//   clk_32f : bit clock, one serial bit per rising edge
//   reset   : asynchronous, active-high
//   bus     : phy_par2serial_if.slave (data_in, valid_in, serial_out, load, active)
module phy_par2serial #(
    parameter int unsigned N_SYNC = 4,        // 1..15
    parameter logic [7:0]  COM    = 8'hBC,
    parameter logic [7:0]  IDLE   = 8'h7C
) (
    input logic             clk_32f,
    input logic             reset,
    phy_par2serial_if.slave bus
);

    typedef enum logic {StSync, StActive} state_e;

    logic [7:0] word_q;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    state_e     state;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            word_q   <= 8'h00;
            bit_cnt  <= 3'd7;   // first edge after release is a load edge
            sync_cnt <= 4'd0;
            state    <= StSync;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                unique case (state)
                    StSync: begin
                        // Upstream words are dropped until alignment is done.
                        word_q   <= COM;
                        sync_cnt <= sync_cnt + 4'd1;
                        if (sync_cnt == 4'(N_SYNC - 1)) begin
                            state <= StActive;
                        end
                    end
                    StActive: begin
                        word_q <= bus.valid_in ? bus.data_in : IDLE;
                    end
                endcase
            end
        end
    end

    // bit_cnt == 0 right after a load, so the MSB leads.
    assign bus.serial_out = word_q[3'd7 - bit_cnt];
    assign bus.load       = (bit_cnt == 3'd7);
    assign bus.active     = (state == StActive);

endmodule

// File: tb/tb_phy_par2serial.sv
// Scoreboard bench for phy_par2serial. A reference model counts edges since
// reset release, decides the word at every 8th edge from the load ordinal and
// the sampled stimulus, and queues its bits; a monitor pops one bit per cycle.
module tb_phy_par2serial;
    localparam int unsigned N_SYNC = 4;
    localparam logic [7:0]  COM    = 8'hBC;
    localparam logic [7:0]  IDLE   = 8'h7C;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    phy_par2serial_if bus ();

    phy_par2serial #(
        .N_SYNC(N_SYNC),
        .COM   (COM),
        .IDLE  (IDLE)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    int unsigned edge_idx  = 0;  // rising edges since reset release
    int unsigned load_cnt  = 0;  // load edges since reset release
    bit          exp_active = 1'b0;
    bit          exp_q[$];
    logic [7:0]  model_word;

    logic [8:0]  stim_q[$];      // {valid, data} per load slot

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words are decided purely by the load ordinal after release.
    initial begin
        forever begin
            @(posedge clk_32f or posedge reset);
            if (reset) begin
                edge_idx   = 0;
                load_cnt   = 0;
                exp_active = 1'b0;
                exp_q.delete();
            end else begin
                if (edge_idx % 8 == 0) begin
                    load_cnt++;
                    if (load_cnt <= N_SYNC) model_word = COM;
                    else model_word = bus.valid_in ? bus.data_in : IDLE;
                    for (int i = 7; i >= 0; i--) exp_q.push_back(model_word[i]);
                    if (load_cnt >= N_SYNC) exp_active = 1'b1;
                end
                edge_idx++;
            end
        end
    end

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        bit b;
        forever begin
            @(posedge clk_32f);
            #2;
            if (!reset) begin
                chk("load", {7'd0, bus.load}, {7'd0, (edge_idx % 8 == 0)});
                chk("active", {7'd0, bus.active}, {7'd0, exp_active});
                if (exp_q.size() == 0) begin
                    chk("serial_underflow", 8'd1, 8'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("serial_out", {7'd0, bus.serial_out}, {7'd0, b});
                end
            end
        end
    end

    // Load slots take the next queued item; every other cycle gets noise.
    task automatic drive_slot();
        logic [8:0] it;
        if (!reset && (edge_idx % 8 == 0)) begin
            if (stim_q.size() > 0) it = stim_q.pop_front();
            else it = {1'b0, 8'($urandom)};
            bus.valid_in = it[8];
            bus.data_in  = it[7:0];
        end else begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.data_in  = 8'($urandom);
        end
    endtask

    task automatic cycle();
        @(negedge clk_32f);
        drive_slot();
    endtask

    task automatic check_reset_outputs();
        chk("rst_serial_out", {7'd0, bus.serial_out}, 8'd0);
        chk("rst_load", {7'd0, bus.load}, 8'd1);
        chk("rst_active", {7'd0, bus.active}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in  = 8'h00;
        bus.valid_in = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_outputs();

        // Valid words offered during alignment must be discarded.
        for (int i = 0; i < int'(N_SYNC); i++) stim_q.push_back({1'b1, 8'h11});
        stim_q.push_back({1'b1, 8'hA5});
        stim_q.push_back({1'b1, 8'h3C});
        stim_q.push_back({1'b1, 8'hFF});
        for (int i = 0; i < 3; i++) begin
            stim_q.push_back({1'b1, 8'h55});
            stim_q.push_back({1'b0, 8'h55});
        end
        stim_q.push_back({1'b1, COM});   // sent unescaped
        stim_q.push_back({1'b1, IDLE});
        for (int i = 0; i < 30; i++) begin
            stim_q.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
        end
        stim_q.push_back({1'b1, 8'hA5});

        repeat (2) cycle();
        @(negedge clk_32f);
        reset = 1'b0;
        drive_slot();

        while (stim_q.size() > 0) cycle();
        repeat (4) cycle();   // now midway through the final A5

        // Mid-word reset held for 3 cycles.
        @(negedge clk_32f);
        reset = 1'b1;
        #1 check_reset_outputs();
        repeat (2) cycle();
        @(negedge clk_32f);
        reset = 1'b0;
        // Alignment with valid low, then fresh random data.
        for (int i = 0; i < int'(N_SYNC); i++) stim_q.push_back({1'b0, 8'h00});
        for (int i = 0; i < 8; i++) begin
            stim_q.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
        end
        drive_slot();
        while (stim_q.size() > 0) cycle();
        repeat (16) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
